// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and the round-robin pick function for the packet arbiter.
package axis_arb_pkg;

  typedef enum logic {ARB, XFER} arb_state_t;

  // Round-robin winner: first set bit of req after 'last', wrapping.
  // req is zero-padded to 16 bits, so the zero bits above N_SRC never win
  // and the result is the same as a wrap at N_SRC.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last);
    logic [3:0] idx;
    logic       found;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 16; k++) begin
      idx = last + 4'(k);
      if (!found && req[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle for the packet arbiter: N_SRC source ports plus one master port.
interface axis_packet_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned ID_WIDTH   = 8
);

  logic [N_SRC-1:0]            s_tvalid;
  logic [N_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [N_SRC-1:0]            s_tlast;
  logic [N_SRC*2-1:0]          s_tuser;
  logic [N_SRC-1:0]            s_tready;

  logic                        m_tvalid;
  logic [DATA_WIDTH-1:0]       m_tdata;
  logic                        m_tlast;
  logic [1:0]                  m_tuser;
  logic [ID_WIDTH-1:0]         m_tid;
  logic [DATA_WIDTH/8-1:0]     m_tkeep;
  logic                        m_tready;

  // Arbiter side: consumes the sources, drives the shared master port.
  modport master (
    input  s_tvalid, s_tdata, s_tlast, s_tuser,
    output s_tready,
    output m_tvalid, m_tdata, m_tlast, m_tuser, m_tid, m_tkeep,
    input  m_tready
  );

  // Environment side: drives the sources, sinks the master port.
  modport slave (
    output s_tvalid, s_tdata, s_tlast, s_tuser,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tlast, m_tuser, m_tid, m_tkeep,
    output m_tready
  );

endinterface

// File: rtl/axis_packet_arbiter_skid.sv
// Two-entry register slice: an output register plus one skid entry.
// in_ready is the registered "skid entry empty" flag, so it never depends
// combinationally on out_ready.
module axis_skid_buf
  import axis_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [1:0]            in_user,
  input  logic [ID_WIDTH-1:0]   in_id,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            out_user,
  output logic [ID_WIDTH-1:0]   out_id,
  input  logic                  out_ready
);

  localparam int unsigned PW = DATA_WIDTH + 1 + 2 + ID_WIDTH;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;
  logic [PW-1:0] skid_pl;
  logic          skid_valid;
  logic          accept;

  assign in_pl    = {in_data, in_last, in_user, in_id};
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign {out_data, out_last, out_user, out_id} = out_pl;

  // Refill the output from the skid entry first, then from the input; park the input in the skid entry on a stall.
  // A beat is only accepted while the skid entry is empty, so no three-way case exists.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      out_valid  <= 1'b0;
      out_pl     <= '0;
      skid_valid <= 1'b0;
      skid_pl    <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_pl     <= skid_pl;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_pl <= in_pl;
      end
    end else if (accept) begin
      skid_pl    <= in_pl;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: N_SRC AXI-Stream sources onto one master
// port. A grant is held from the first beat to the TLAST handshake; every beat
// is tagged with the source index and registered through a skid buffer.
// A reset mid-packet drops the partial packet without a TLAST; downstream must tolerate it.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned N_SRC      = 4,
  parameter  int unsigned ID_WIDTH   = 8,
  localparam int unsigned GW         = $clog2(N_SRC)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [N_SRC-1:0]        src_en,
  axis_packet_arbiter_if.master   axis,
  output logic                    busy,
  output logic [GW-1:0]           grant_idx
);

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [N_SRC-1:0]      req;
  logic                  skid_in_ready;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic [1:0]            sel_user;
  logic                  in_valid;
  logic                  accept;

  assign req       = axis.s_tvalid & src_en;
  assign busy      = (state_q == XFER);
  assign grant_idx = grant_q;
  assign axis.m_tkeep = '1;

  // Input mux: the granted source's beat.
  always_comb begin
    sel_valid = axis.s_tvalid[grant_q];
    sel_data  = axis.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    sel_last  = axis.s_tlast[grant_q];
    sel_user  = axis.s_tuser[grant_q*2 +: 2];
  end

  assign in_valid = (state_q == XFER) && sel_valid;
  assign accept   = in_valid && skid_in_ready;

  // State and grant registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ARB;
      grant_q <= GW'(N_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next state, grant selection and per-source ready.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    axis.s_tready = '0;
    unique case (state_q)
      ARB: begin
        if (|req) begin
          grant_d = GW'(rr_next(16'(req), 4'(grant_q)));
          state_d = XFER;
        end
      end
      XFER: begin
        axis.s_tready[grant_q] = skid_in_ready;
        if (accept && sel_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_skid (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .in_valid  (in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (sel_data),
    .in_last   (sel_last),
    .in_user   (sel_user),
    .in_id     (ID_WIDTH'(grant_q)),
    .out_valid (axis.m_tvalid),
    .out_data  (axis.m_tdata),
    .out_last  (axis.m_tlast),
    .out_user  (axis.m_tuser),
    .out_id    (axis.m_tid),
    .out_ready (axis.m_tready)
  );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: stimulus pushes expected beats,
// a negedge monitor pops and compares every master handshake.
module tb_axis_packet_arbiter;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int IW = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  user;
    logic [7:0]  tid;
  } beat_t;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic [3:0] src_en;
  logic       busy;
  logic [1:0] grant_idx;

  axis_packet_arbiter_if #(.DATA_WIDTH(DW), .N_SRC(NS), .ID_WIDTH(IW)) axis ();

  axis_packet_arbiter #(.DATA_WIDTH(DW), .N_SRC(NS), .ID_WIDTH(IW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .src_en    (src_en),
    .axis      (axis),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 ACLK = ~ACLK;

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  beat_t srcq[4][$];
  beat_t expq[$];
  int    outcyc[$];
  int    acc[4];
  bit    tog_en = 0;
  bit    en_mon = 0;
  int    bad = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int src, input int n, input logic [15:0] base, input bit push_exp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 16'(k);
      b.last = (k == n - 1);
      b.user = 2'(k);
      b.tid  = 8'(src);
      srcq[src].push_back(b);
      if (push_exp) expq.push_back(b);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      srcq[i].delete();
      acc[i] = 0;
    end
    expq.delete();
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        b = srcq[i][0];
        axis.s_tvalid[i]        = 1'b1;
        axis.s_tdata[i*16 +: 16] = b.data;
        axis.s_tlast[i]         = b.last;
        axis.s_tuser[i*2 +: 2]  = b.user;
      end else begin
        axis.s_tvalid[i] = 1'b0;
        axis.s_tlast[i]  = 1'b0;
      end
    end
  endtask

  // Source driver: retire handshaken beats, then present each queue head.
  initial begin
    logic [3:0] hs;
    forever begin
      @(negedge ACLK);
      hs = axis.s_tvalid & axis.s_tready;
      @(posedge ACLK);
      #1;
      for (int i = 0; i < 4; i++)
        if (hs[i] && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          acc[i]++;
        end
      if (tog_en) axis.m_tready = ~axis.m_tready;
      drive();
    end
  end

  // Monitor: compare each master beat with the scoreboard and check stall stability.
  initial begin
    beat_t cur, e;
    beat_t prev;
    bit    stall_prev;
    stall_prev = 0;
    prev = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        stall_prev = 0;
      end else begin
        cur = {axis.m_tdata, axis.m_tlast, axis.m_tuser, axis.m_tid};
        if (stall_prev) begin
          chk("stall_valid", 32'(axis.m_tvalid), 32'd1);
          chk("stall_hold", 32'(cur), 32'(prev));
        end
        if (axis.m_tvalid && axis.m_tready) begin
          if (expq.size() == 0) begin
            chk("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            chk("beat", 32'(cur), 32'(e));
            outcyc.push_back(cyc);
          end
        end
        stall_prev = axis.m_tvalid && !axis.m_tready;
        prev = cur;
        if (en_mon && (axis.s_tready[1] || axis.s_tready[3])) bad++;
      end
    end
  end

  task automatic do_reset();
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    flush();
    repeat (2) @(negedge ACLK);
    chk("rst_m_tvalid", 32'(axis.m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(axis.m_tlast), 32'd0);
    chk("rst_m_tdata", 32'(axis.m_tdata), 32'd0);
    chk("rst_m_tid", 32'(axis.m_tid), 32'd0);
    chk("rst_s_tready", 32'(axis.s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd3);
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    chk({name, "_drain"}, 32'(expq.size()), 32'd0);
    repeat (3) @(negedge ACLK);
  endtask

  initial begin
    int t0;
    src_en          = 4'b1111;
    axis.m_tready   = 1'b1;
    axis.s_tvalid   = '0;
    axis.s_tdata    = '0;
    axis.s_tlast    = '0;
    axis.s_tuser    = '0;

    // 3-beat packet from source 0, latency from s_tvalid to m_tvalid
    do_reset();
    chk("tkeep", 32'(axis.m_tkeep), 32'h3);
    outcyc.delete();
    @(negedge ACLK);
    add_pkt(0, 3, 16'h0001, 1);
    @(posedge ACLK);
    #2;
    t0 = cyc;
    wait_drain("t1", 50);
    chk("t1_beats", 32'(outcyc.size()), 32'd3);
    chk("t1_latency", outcyc.size() > 0 ? 32'(outcyc[0] - t0) : 32'hFFFF, 32'd2);

    // all four sources, grant order 0,1,2,3,0 with one bubble between packets
    do_reset();
    outcyc.delete();
    @(negedge ACLK);
    add_pkt(0, 2, 16'h0100, 1);
    add_pkt(1, 2, 16'h1100, 1);
    add_pkt(2, 2, 16'h2100, 1);
    add_pkt(3, 2, 16'h3100, 1);
    add_pkt(0, 2, 16'h0200, 1);
    wait_drain("t2", 100);
    chk("t2_beats", 32'(outcyc.size()), 32'd10);
    for (int k = 1; k < 10 && k < outcyc.size(); k++)
      chk("t2_gap", 32'(outcyc[k] - outcyc[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);

    // 6-beat packet with m_tready toggling every cycle
    do_reset();
    @(negedge ACLK);
    tog_en = 1;
    add_pkt(2, 6, 16'h2A00, 1);
    wait_drain("t3", 100);
    tog_en = 0;
    axis.m_tready = 1'b1;

    // src_en = 0101: only sources 0 and 2, alternating
    do_reset();
    src_en = 4'b0101;
    bad = 0;
    en_mon = 1;
    @(negedge ACLK);
    add_pkt(0, 1, 16'h0400, 1);
    add_pkt(2, 1, 16'h2400, 1);
    add_pkt(0, 1, 16'h0500, 1);
    add_pkt(2, 1, 16'h2500, 1);
    add_pkt(1, 1, 16'h1400, 0);
    add_pkt(3, 1, 16'h3400, 0);
    wait_drain("t4", 100);
    chk("t4_masked_ready", 32'(bad), 32'd0);
    chk("t4_masked_accepts", 32'(acc[1] + acc[3]), 32'd0);
    en_mon = 0;
    src_en = 4'b1111;

    // reset after two beats of a 4-beat packet are accepted
    do_reset();
    axis.m_tready = 1'b0;
    @(negedge ACLK);
    add_pkt(0, 4, 16'h0600, 0);
    begin
      int n;
      n = 0;
      while (acc[0] < 2 && n < 50) begin
        @(posedge ACLK);
        #2;
        n++;
      end
      chk("t5_two_accepted", 32'(acc[0]), 32'd2);
    end
    chk("t5_pre_valid", 32'(axis.m_tvalid), 32'd1);
    ARESET = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(axis.m_tvalid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    flush();
    repeat (2) @(negedge ACLK);
    axis.m_tready = 1'b1;
    ARESET = 1'b0;
    @(negedge ACLK);
    add_pkt(0, 1, 16'h0A0A, 1);
    add_pkt(1, 1, 16'h1B1B, 1);
    wait_drain("t5", 50);

    // single-beat packets back-to-back from source 3 only
    do_reset();
    outcyc.delete();
    @(negedge ACLK);
    add_pkt(3, 1, 16'h3001, 1);
    add_pkt(3, 1, 16'h3002, 1);
    add_pkt(3, 1, 16'h3003, 1);
    add_pkt(3, 1, 16'h3004, 1);
    wait_drain("t6", 60);
    chk("t6_beats", 32'(outcyc.size()), 32'd4);
    for (int k = 1; k < 4 && k < outcyc.size(); k++)
      chk("t6_rate", 32'(outcyc[k] - outcyc[k-1]), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
